dcqcn_timeout_scheduler: RTL

- Upstream of the DCQCN timeout handler. Keeps one earliest-deadline entry per flow (the minimum of the alpha, rate-increase and rtx timers) and scans all flows round-robin.
- Issues a single timeout event per expired flow, with a valid/ready handshake, to the timeout-processing stage.
- The processing stage writes its new earliest deadline back through the arm port. Its timer results use the same 500-tick early-fire slack.

---
 rtl/dcqcn_timeout_scheduler_pkg.sv | 22 ++
 rtl/dcqcn_deadline_ram.sv | 59 +++++
 rtl/dcqcn_timeout_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dcqcn_timeout_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcqcn_timeout_scheduler_pkg
// Brief    : Shared DCQCN constants and timeout-scheduler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package dcqcn_timeout_scheduler_pkg;

    localparam int unsigned DCQCN_FLOW_NUM    = 1024;
    localparam int unsigned DCQCN_FLOW_ID_W   = 10;
    localparam int unsigned DCQCN_TIMER_W     = 32;
    // Early-fire slack, identical to the timeout handler's own timer slack
    localparam int unsigned DCQCN_EARLY_SLACK = 500;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } sched_state_e;

endpackage : dcqcn_timeout_scheduler_pkg
`default_nettype wire

// File: rtl/dcqcn_deadline_ram.sv
`default_nettype none
// ============================================================================
// Module   : dcqcn_deadline_ram
// Brief    : Per-flow armed bit plus deadline store, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module dcqcn_deadline_ram
    import dcqcn_timeout_scheduler_pkg::*;
#(
    parameter int unsigned FLOW_NUM  = DCQCN_FLOW_NUM,
    parameter int unsigned FLOW_ID_W = DCQCN_FLOW_ID_W,
    parameter int unsigned TIMER_W   = DCQCN_TIMER_W
) (
    input  logic                 clk,
    input  logic                 arm_en,
    input  logic [FLOW_ID_W-1:0] arm_idx,
    input  logic [TIMER_W-1:0]   arm_deadline,
    input  logic                 disarm_en,
    input  logic [FLOW_ID_W-1:0] disarm_idx,
    input  logic                 clear_en,
    input  logic [FLOW_ID_W-1:0] clear_idx,
    input  logic                 rd_en,
    input  logic [FLOW_ID_W-1:0] rd_idx,
    output logic                 rd_armed,
    output logic [TIMER_W-1:0]   rd_deadline
);

    logic [FLOW_NUM-1:0] w_armed;
    logic [TIMER_W-1:0]  r_mem [FLOW_NUM];

    // Arming takes priority over any same-cycle clear of the same flow
    for (genvar i = 0; i < FLOW_NUM; i++) begin : g_armed
        logic r_bit;
        always_ff @(posedge clk) begin
            if (arm_en && (arm_idx == FLOW_ID_W'(i))) begin
                r_bit <= 1'b1;
            end else if ((disarm_en && (disarm_idx == FLOW_ID_W'(i))) ||
                         (clear_en  && (clear_idx  == FLOW_ID_W'(i)))) begin
                r_bit <= 1'b0;
            end
        end
        assign w_armed[i] = r_bit;
    end

    always_ff @(posedge clk) begin
        if (arm_en) begin
            r_mem[arm_idx] <= arm_deadline;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_armed    <= w_armed[rd_idx];
            rd_deadline <= r_mem[rd_idx];
        end
    end

endmodule : dcqcn_deadline_ram
`default_nettype wire

// File: rtl/dcqcn_timeout_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dcqcn_timeout_scheduler
// Brief    : Round-robin earliest-deadline scan issuing one timeout per flow.
// Revision : 1.0 - initial release
// ============================================================================
module dcqcn_timeout_scheduler
    import dcqcn_timeout_scheduler_pkg::*;
#(
    parameter int unsigned FLOW_NUM    = DCQCN_FLOW_NUM,
    parameter int unsigned FLOW_ID_W   = DCQCN_FLOW_ID_W,
    parameter int unsigned TIMER_W     = DCQCN_TIMER_W,
    parameter int unsigned EARLY_SLACK = DCQCN_EARLY_SLACK
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TIMER_W-1:0]   now,
    input  logic                 arm_valid,
    output logic                 arm_ready,
    input  logic [FLOW_ID_W-1:0] arm_flow_id,
    input  logic [TIMER_W-1:0]   arm_deadline,
    input  logic                 disarm_valid,
    input  logic [FLOW_ID_W-1:0] disarm_flow_id,
    output logic                 to_valid,
    input  logic                 to_ready,
    output logic [FLOW_ID_W-1:0] to_flow_id,
    output logic [TIMER_W-1:0]   to_deadline,
    output logic                 init_done
);

    localparam logic [FLOW_ID_W-1:0] c_last_idx = FLOW_ID_W'(FLOW_NUM - 1);
    localparam logic [TIMER_W-1:0]   c_slack    = TIMER_W'(EARLY_SLACK);

    sched_state_e           r_state;
    sched_state_e           w_state_nxt;
    logic [FLOW_ID_W-1:0]   r_scan_idx;
    logic                   r_s1_valid;
    logic [FLOW_ID_W-1:0]   r_s1_idx;
    logic                   r_s1_hazard;
    logic                   r_to_valid;
    logic [FLOW_ID_W-1:0]   r_to_flow_id;
    logic [TIMER_W-1:0]     r_to_deadline;
    logic                   r_arm_ready;
    logic                   r_init_done;

    logic                   w_rd_en;
    logic                   w_clear_en;
    logic [FLOW_ID_W-1:0]   w_clear_idx;
    logic                   w_rd_armed;
    logic [TIMER_W-1:0]     w_rd_deadline;

    logic                   w_arm_fire;
    logic                   w_disarm_fire;
    logic                   w_handshake;
    logic [TIMER_W-1:0]     w_diff;
    logic                   w_expired;
    logic                   w_s0_collide;
    logic                   w_s1_collide;
    logic                   w_fire;

    assign arm_ready   = r_arm_ready;
    assign init_done   = r_init_done;
    assign to_valid    = r_to_valid;
    assign to_flow_id  = r_to_flow_id;
    assign to_deadline = r_to_deadline;

    assign w_arm_fire    = arm_valid & r_arm_ready;
    assign w_disarm_fire = disarm_valid & r_init_done;
    assign w_handshake   = (r_state == ST_HOLD) & r_to_valid & to_ready;

    // Wrap-safe compare: expired once now + slack has reached the deadline
    assign w_diff    = now + c_slack - w_rd_deadline;
    assign w_expired = ~w_diff[TIMER_W-1];

    // Any write to a flow whose read is in flight makes that read stale
    assign w_s0_collide = (w_arm_fire    && (arm_flow_id    == r_scan_idx)) ||
                          (w_disarm_fire && (disarm_flow_id == r_scan_idx));
    assign w_s1_collide = (w_arm_fire    && (arm_flow_id    == r_s1_idx)) ||
                          (w_disarm_fire && (disarm_flow_id == r_s1_idx));

    assign w_fire = (r_state == ST_SCAN) & r_s1_valid & ~r_s1_hazard &
                    ~w_s1_collide & w_rd_armed & w_expired;

    dcqcn_deadline_ram #(
        .FLOW_NUM   (FLOW_NUM),
        .FLOW_ID_W  (FLOW_ID_W),
        .TIMER_W    (TIMER_W)
    ) u_deadline_ram (
        .clk          (clk),
        .arm_en       (w_arm_fire),
        .arm_idx      (arm_flow_id),
        .arm_deadline (arm_deadline),
        .disarm_en    (w_disarm_fire),
        .disarm_idx   (disarm_flow_id),
        .clear_en     (w_clear_en),
        .clear_idx    (w_clear_idx),
        .rd_en        (w_rd_en),
        .rd_idx       (r_scan_idx),
        .rd_armed     (w_rd_armed),
        .rd_deadline  (w_rd_deadline)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_clear_en  = 1'b0;
        w_clear_idx = r_scan_idx;
        case (r_state)
            ST_INIT: begin
                w_clear_en = 1'b1;
                if (r_scan_idx == c_last_idx) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_rd_en = 1'b1;
                if (w_fire) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_clear_idx = r_to_flow_id;
                if (w_handshake) begin
                    w_clear_en  = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_INIT;
            r_scan_idx    <= '0;
            r_s1_valid    <= 1'b0;
            r_s1_idx      <= '0;
            r_s1_hazard   <= 1'b0;
            r_to_valid    <= 1'b0;
            r_to_flow_id  <= '0;
            r_to_deadline <= '0;
            r_arm_ready   <= 1'b0;
            r_init_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_INIT: begin
                    r_scan_idx <= r_scan_idx + FLOW_ID_W'(1);
                    if (r_scan_idx == c_last_idx) begin
                        r_init_done <= 1'b1;
                        r_arm_ready <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_fire) begin
                        // Scan index is left on the in-flight read so it replays on exit
                        r_to_valid    <= 1'b1;
                        r_to_flow_id  <= r_s1_idx;
                        r_to_deadline <= w_rd_deadline;
                        r_s1_valid    <= 1'b0;
                    end else begin
                        r_s1_valid  <= 1'b1;
                        r_s1_idx    <= r_scan_idx;
                        r_s1_hazard <= w_s0_collide;
                        r_scan_idx  <= r_scan_idx + FLOW_ID_W'(1);
                    end
                end
                ST_HOLD: begin
                    r_s1_valid <= 1'b0;
                    if (w_handshake) begin
                        r_to_valid <= 1'b0;
                    end
                end
                default: begin
                    r_s1_valid <= 1'b0;
                    r_to_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : dcqcn_timeout_scheduler
`default_nettype wire
